alu_core: RTL and testbench
===========================

ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 The module SHALL have exactly the following ports, clock and reset first.
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in1  input  32  operand A.
- in2  input  32  operand B, before the shifter.
- s  input  1  set-flags enable.
- cond  input  4  condition code.
- opcode  input  4  operation select.
- srctrl  input  3  shift/rotate control applied to in2.
- imvalue  input  16  immediate; bits [4:0] also give the shift amount.
- flags  output  32? no: 4  registered {N,Z,C,V}; N is bit 3, V is bit 0.
- result  output  32  registered result.

Function
REQ-002 Outputs SHALL be registered, with 1-cycle latency: inputs sampled at edge k appear on result/flags after edge k.
REQ-003 Shift amount = imvalue[4:0]; op2 is derived from in2 by srctrl:
- 000: in2 (no shift).
- 001: LSL.
- 010: LSR.
- 011: ASR.
- 100: ROR.
- 101-111: behave as 000.
REQ-004 Shifter carry (sc) = last bit shifted out. For shift amount 0 or srctrl 000, sc = current C.
REQ-005 Opcodes SHALL be:
- 0 ADD = in1+op2.
- 1 SUB = in1-op2.
- 2 AND.
- 3 ORR.
- 4 EOR.
- 5 BIC = in1&~op2.
- 6 MOV = op2.
- 7 MVN = ~op2.
- 8 CMP: flags of in1-op2, no result write.
- 9 TST: flags of in1&op2, no result write.
- 10 MOVI = {16'b0, imvalue}.
- 11-14 reserved: result 0, flags hold.
- 15 NOP: result and flags hold.
REQ-006 Arithmetic SHALL be 32-bit modulo 2^32.
- ADD: C = carry out of bit 31; V = signed overflow.
- SUB/CMP: C = 1 when no borrow (in1 >= op2 unsigned); V = signed overflow.
REQ-007 Logical ops, MOV, MVN and TST SHALL set C = sc and leave V unchanged. MOVI SHALL leave C and V unchanged.
REQ-008 N = result[31] and Z = (result == 0), computed on the 32-bit value before registering.
REQ-009 Flags update only when the condition passes and either s=1 or the opcode is CMP/TST.
REQ-010 Conditions SHALL be evaluated on the current flags register. When a condition fails, result and flags hold.
- 0 AL.
- 1 EQ (Z).
- 2 NE (!Z).
- 3 CS (C).
- 4 CC (!C).
- 5 MI (N).
- 6 PL (!N).
- 7 VS (V).
- 8 VC (!V).
- 9 HI (C&!Z).
- 10 LS (!C|Z).
- 11 GE (N==V).
- 12 LT (N!=V).
- 13 GT (!Z&N==V).
- 14 LE (Z|N!=V).
- 15 NV (never).
REQ-011 Back-to-back operations SHALL be supported. A conditional op at edge k+1 SHALL see the flags written at edge k.
REQ-012 The block SHALL be combinational apart from the result and flags registers, with no other state.

Reset
REQ-013 While rst_n=0, result SHALL be 32'h0 and flags 4'b0000, immediately and independent of clk.
REQ-014 Reset asserted mid-operation SHALL discard the pending op; the first edge after release executes normally.

Configuration
REQ-015 Macro ALU_SHIFTER_EN:
- Defined: REQ-003/REQ-004 apply.
- Undefined: op2 = in2 for all srctrl values, srctrl is ignored, and sc = current C.

Verification
REQ-016 Reset, then cond=0, s=1, opcode=0, in1=5, in2=11, srctrl=0 -> result=16, flags=0000.
REQ-017 opcode=1, in1=5, in2=11 -> result=32'hFFFFFFFA, flags N=1 Z=0 C=0 V=0.
REQ-018 Shifter (ALU_SHIFTER_EN) and NOP:
- opcode=0, srctrl=001, imvalue=16'h5416 (shift 22), in1=5, in2=11 -> result=46137349.
- Then opcode=15 -> result and flags unchanged.
REQ-019 Conditional execution:
- CMP 10,10 -> Z=1, C=1.
- Next cycle cond=1 (EQ) ADD 7+6 -> result=13.
- Then cond=2 (NE) ADD 5+33 -> result stays 13.
REQ-020 Carry and reset:
- ADD 0+32'hFFFFFFFF -> result=32'hFFFFFFFF, N=1.
- ADD 5+32'hFFFFFFFF -> result=4, C=1, Z=0.
- Then assert rst_n=0 between edges -> result=0, flags=0000 at once.
REQ-021 s=0, opcode=1, in1=in2=3 -> result=0, flags unchanged from the previous value.

Source files
------------

// File: rtl/alu_core.sv
// alu_core: single-stage ALU with optional barrel shifter on operand B,
// condition-gated execution and a registered {N,Z,C,V} flags word.
// Ports: clk, rst_n (async, active-low), in1/in2 operands, s set-flags,
//   cond condition code, opcode, srctrl shift select, imvalue immediate
//   (bits [4:0] = shift amount), flags {N,Z,C,V}, result.
// Macro ALU_SHIFTER_EN enables the shifter; undefined, op2 = in2.
module alu_core (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] in1,
   input  logic [31:0] in2,
   input  logic        s,
   input  logic [3:0]  cond,
   input  logic [3:0]  opcode,
   input  logic [2:0]  srctrl,
   input  logic [15:0] imvalue,
   output logic [3:0]  flags,
   output logic [31:0] result
);

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_ORR  = 4'd3,
      OP_EOR  = 4'd4,
      OP_BIC  = 4'd5,
      OP_MOV  = 4'd6,
      OP_MVN  = 4'd7,
      OP_CMP  = 4'd8,
      OP_TST  = 4'd9,
      OP_MOVI = 4'd10,
      OP_R11  = 4'd11,
      OP_R12  = 4'd12,
      OP_R13  = 4'd13,
      OP_R14  = 4'd14,
      OP_NOP  = 4'd15
   } op_e;

   op_e op;
   assign op = op_e'(opcode);

   logic fn, fz, fc, fv;
   assign {fn, fz, fc, fv} = flags;

   // operand B after the shifter, plus the shifter carry-out
   logic [31:0] op2;
   logic        sc;

`ifdef ALU_SHIFTER_EN
   logic [4:0] sh;
   logic [5:0] rsh;
   assign sh  = imvalue[4:0];
   assign rsh = 6'd32 - {1'b0, sh};

   always_comb begin
      op2 = in2;
      sc  = fc;
      if (sh != 5'd0) begin
         case (srctrl)
            3'b001: {sc, op2} = {1'b0, in2} << sh;
            3'b010: {op2, sc} = {in2, 1'b0} >> sh;
            3'b011: {op2, sc} = $signed({in2, 1'b0}) >>> sh;
            3'b100: begin
               op2 = (in2 >> sh) | (in2 << rsh);
               // rotate: last bit out lands in bit 31
               sc  = op2[31];
            end
            default: begin
               op2 = in2;
               sc  = fc;
            end
         endcase
      end
   end
`else
   logic unused_srctrl;
   assign unused_srctrl = ^srctrl;
   assign op2 = in2;
   assign sc  = fc;
`endif

   // condition check against the current flags register
   logic pass;
   always_comb begin
      pass = 1'b0;
      case (cond)
         4'd0:  pass = 1'b1;
         4'd1:  pass = fz;
         4'd2:  pass = ~fz;
         4'd3:  pass = fc;
         4'd4:  pass = ~fc;
         4'd5:  pass = fn;
         4'd6:  pass = ~fn;
         4'd7:  pass = fv;
         4'd8:  pass = ~fv;
         4'd9:  pass = fc & ~fz;
         4'd10: pass = ~fc | fz;
         4'd11: pass = (fn == fv);
         4'd12: pass = (fn != fv);
         4'd13: pass = ~fz & (fn == fv);
         4'd14: pass = fz | (fn != fv);
         default: pass = 1'b0;
      endcase
   end

   logic [32:0] sum;
   logic [32:0] diff;
   assign sum  = {1'b0, in1} + {1'b0, op2};
   assign diff = {1'b0, in1} - {1'b0, op2};

   logic [31:0] val;
   logic        cn, vn;
   logic        wr_res, fl_en, force_fl;

   always_comb begin
      val      = result;
      cn       = fc;
      vn       = fv;
      wr_res   = 1'b0;
      fl_en    = 1'b0;
      force_fl = 1'b0;
      unique case (op)
         OP_ADD: begin
            val    = sum[31:0];
            cn     = sum[32];
            vn     = (in1[31] == op2[31]) & (sum[31] != in1[31]);
            wr_res = 1'b1;
            fl_en  = 1'b1;
         end
         OP_SUB, OP_CMP: begin
            val      = diff[31:0];
            // C means no borrow
            cn       = ~diff[32];
            vn       = (in1[31] != op2[31]) & (diff[31] != in1[31]);
            wr_res   = (op == OP_SUB);
            fl_en    = 1'b1;
            force_fl = (op == OP_CMP);
         end
         OP_AND, OP_ORR, OP_EOR, OP_BIC,
         OP_MOV, OP_MVN, OP_TST: begin
            case (op)
               OP_AND, OP_TST: val = in1 & op2;
               OP_ORR:         val = in1 | op2;
               OP_EOR:         val = in1 ^ op2;
               OP_BIC:         val = in1 & ~op2;
               OP_MOV:         val = op2;
               default:        val = ~op2;
            endcase
            cn       = sc;
            wr_res   = (op != OP_TST);
            fl_en    = 1'b1;
            force_fl = (op == OP_TST);
         end
         OP_MOVI: begin
            val    = {16'h0, imvalue};
            wr_res = 1'b1;
            fl_en  = 1'b1;
         end
         OP_R11, OP_R12, OP_R13, OP_R14: begin
            val    = 32'h0;
            wr_res = 1'b1;
         end
         default: begin
            val = result;
         end
      endcase
   end

   logic [3:0] flg_d;
   logic       res_we, flg_we;
   assign flg_d  = {val[31], (val == 32'h0), cn, vn};
   assign res_we = pass & wr_res;
   assign flg_we = pass & fl_en & (s | force_fl);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result <= 32'h0;
         flags  <= 4'h0;
      end else begin
         if (res_we) result <= val;
         if (flg_we) flags  <= flg_d;
      end
   end

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: scoreboard bench for alu_core.
// Expected {result,flags} are queued at drive time and popped after the edge.
module tb_alu_core;

   logic        clk;
   logic        rst_n;
   logic [31:0] in1, in2;
   logic        s;
   logic [3:0]  cond, opcode;
   logic [2:0]  srctrl;
   logic [15:0] imvalue;
   logic [3:0]  flags;
   logic [31:0] result;

   alu_core dut (
      .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2), .s(s),
      .cond(cond), .opcode(opcode), .srctrl(srctrl),
      .imvalue(imvalue), .flags(flags), .result(result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nerr = 0;
   int nchk = 0;

   logic [31:0] m_res;
   logic [3:0]  m_flg;
   logic [35:0] sbq[$];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // independent reference model, 64-bit shifting and longint arithmetic
   task automatic m_step(input logic [3:0] c, input logic sb,
                         input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] sr,
                         input logic [15:0] im);
      logic n, z, cf, v, ok, sc, wr, fw;
      logic [31:0] o2, r;
      logic [63:0] t;
      longint x;
      int k;
      {n, z, cf, v} = m_flg;
      case (c)
         0: ok = 1;           1: ok = z;
         2: ok = !z;          3: ok = cf;
         4: ok = !cf;         5: ok = n;
         6: ok = !n;          7: ok = v;
         8: ok = !v;          9: ok = cf && !z;
         10: ok = !cf || z;   11: ok = (n == v);
         12: ok = (n != v);   13: ok = !z && (n == v);
         14: ok = z || (n != v);
         default: ok = 0;
      endcase
      o2 = b;
      sc = cf;
      k  = int'(im[4:0]);
`ifdef ALU_SHIFTER_EN
      if (k != 0) begin
         case (sr)
            3'd1: begin t = {32'h0, b} << k; o2 = t[31:0]; sc = t[32]; end
            3'd2: begin t = {b, 32'h0} >> k; o2 = t[63:32]; sc = t[31]; end
            3'd3: begin
               t = $signed({b, 32'h0}) >>> k;
               o2 = t[63:32]; sc = t[31];
            end
            3'd4: begin t = {b, b} >> k; o2 = t[31:0]; sc = o2[31]; end
            default: ;
         endcase
      end
`endif
      if (!ok) return;
      r  = m_res;
      wr = 1;
      fw = 1;
      case (op)
         0: begin
            r = a + o2; cf = (r < a);
            x = longint'($signed(a)) + longint'($signed(o2));
            v = (x > 64'sd2147483647) || (x < -64'sd2147483648);
         end
         1, 8: begin
            r = a - o2; cf = (a >= o2);
            x = longint'($signed(a)) - longint'($signed(o2));
            v = (x > 64'sd2147483647) || (x < -64'sd2147483648);
            wr = (op == 1);
         end
         2: begin r = a & o2;  cf = sc; end
         3: begin r = a | o2;  cf = sc; end
         4: begin r = a ^ o2;  cf = sc; end
         5: begin r = a & ~o2; cf = sc; end
         6: begin r = o2;      cf = sc; end
         7: begin r = ~o2;     cf = sc; end
         9: begin r = a & o2;  cf = sc; wr = 0; end
         10: r = {16'h0, im};
         11, 12, 13, 14: begin r = 0; fw = 0; end
         default: begin wr = 0; fw = 0; end
      endcase
      if (fw && (sb || op == 8 || op == 9))
         m_flg = {r[31], (r == 0), cf, v};
      if (wr) m_res = r;
   endtask

   task automatic op(input logic [3:0] c, input logic sb,
                     input logic [3:0] opc, input logic [31:0] a,
                     input logic [31:0] b, input logic [2:0] sr,
                     input logic [15:0] im);
      logic [35:0] e;
      @(negedge clk);
      cond = c; s = sb; opcode = opc; in1 = a; in2 = b;
      srctrl = sr; imvalue = im;
      m_step(c, sb, opc, a, b, sr, im);
      sbq.push_back({m_res, m_flg});
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
         chk("sb_empty", 32'h1, 32'h0);
      end else begin
         e = sbq.pop_front();
         chk("res", result, e[35:4]);
         chk("flg", {28'h0, flags}, {28'h0, e[3:0]});
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return 32'h7FFFFFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 0; in1 = 0; in2 = 0; s = 0; cond = 0;
      opcode = 4'd15; srctrl = 0; imvalue = 0;
      m_res = 0; m_flg = 0;
      #2;
      chk("rst_res", result, 32'h0);
      chk("rst_flg", {28'h0, flags}, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1;

      op(0, 1, 0, 5, 11, 0, 0);
      chk("add16", result, 32'd16);
      chk("add16f", {28'h0, flags}, 32'h0);
      op(0, 1, 1, 5, 11, 0, 0);
      chk("sub", result, 32'hFFFFFFFA);
      chk("subf", {28'h0, flags}, 32'h8);
      op(0, 1, 0, 5, 11, 3'b001, 16'h5416);
`ifdef ALU_SHIFTER_EN
      chk("lsl22", result, 32'd46137349);
`else
      chk("noshift", result, 32'd16);
`endif
      op(0, 1, 15, 1, 2, 0, 0);
`ifdef ALU_SHIFTER_EN
      chk("nop", result, 32'd46137349);
`else
      chk("nop", result, 32'd16);
`endif
      op(0, 0, 8, 10, 10, 0, 0);
      chk("cmpzc", {30'h0, flags[2:1]}, 32'h3);
      op(1, 0, 0, 7, 6, 0, 0);
      chk("eq", result, 32'd13);
      op(2, 0, 0, 5, 33, 0, 0);
      chk("ne", result, 32'd13);
      op(0, 1, 0, 0, 32'hFFFFFFFF, 0, 0);
      chk("addm1", result, 32'hFFFFFFFF);
      chk("addm1n", {31'h0, flags[3]}, 32'h1);
      op(0, 1, 0, 5, 32'hFFFFFFFF, 0, 0);
      chk("carry", result, 32'd4);
      chk("carryf", {28'h0, flags}, 32'h2);
      op(0, 0, 1, 3, 3, 0, 0);
      chk("s0sub", result, 32'h0);
      chk("s0subf", {28'h0, flags}, 32'h2);

      // reset between edges, with an op pending
      @(negedge clk);
      opcode = 4'd0; in1 = 1; in2 = 2; s = 1; cond = 0;
      #1 rst_n = 0;
      #1;
      chk("arst_res", result, 32'h0);
      chk("arst_flg", {28'h0, flags}, 32'h0);
      @(posedge clk);
      #1;
      chk("hold_res", result, 32'h0);
      m_res = 0; m_flg = 0;
      sbq.delete();
      opcode = 4'd15;
      @(negedge clk);
      rst_n = 1;
      op(0, 1, 0, 1, 2, 0, 0);
      chk("post_rst", result, 32'd3);

      for (int i = 0; i < 300; i++)
         op(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), pick(), pick(),
            3'($urandom_range(0, 7)), 16'($urandom));

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
